// File: rtl/titan_wb_arbiter_pkg.sv
// Shared definitions for the titan Wishbone arbiter: grant FSM encodings,
// grant identifiers and the fixed attributes of instruction-port requests.
package titan_arb_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic ARB_I = 1'b0;
    localparam logic ARB_D = 1'b1;

    // Instruction fetches are always full-word reads.
    localparam logic [3:0] I_SEL = 4'hF;
    localparam logic       I_WE  = 1'b0;

endpackage

// File: rtl/titan_arb_timeout.sv
// Granted-cycle watchdog: counts cycles a granted transfer waits for ack/err
// and flags expiry once the count reaches TIMEOUT_CYCLES.
module titan_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expire
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt;

    // Held at zero while idle so every grant starts from a cleared count.
    always_ff @(posedge clk) begin
        if (rst || !active)
            cnt <= 8'd0;
        else if (!done && cnt != LIMIT)
            cnt <= cnt + 8'd1;
    end

    assign expire = active && !done && (cnt == LIMIT);

endmodule

// File: rtl/titan_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 classic master between the
// titan_core instruction and data ports. Optional watchdog: TITAN_WB_ARB_TIMEOUT_EN.
module titan_wb_arbiter
    import titan_arb_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] iwbs_addr_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic        dwbs_we_i,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    arb_state_t state, state_n;
    logic       last_grant, last_grant_n;
    logic       expire;

    wire i_req     = iwbs_cyc_i & iwbs_stb_i;
    wire d_req     = dwbs_cyc_i & dwbs_stb_i;
    wire own_i     = (state == GNT_I);
    wire own_d     = (state == GNT_D);
    wire bus_done  = wbm_ack_i | wbm_err_i;

`ifdef TITAN_WB_ARB_TIMEOUT_EN
    titan_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk_i),
        .rst    (rst_i),
        .active (own_i | own_d),
        .done   (bus_done),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= ARB_I;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_grant == ARB_D)) begin
                    state_n      = GNT_I;
                    last_grant_n = ARB_I;
                end else if (d_req) begin
                    state_n      = GNT_D;
                    last_grant_n = ARB_D;
                end
            end
            // An owner dropping cyc (fetch kill) ends the grant like a completion.
            GNT_I: if (bus_done || expire || !iwbs_cyc_i) state_n = IDLE;
            GNT_D: if (bus_done || expire || !dwbs_cyc_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        wbm_addr_o = 32'd0;
        wbm_dat_o  = 32'd0;
        wbm_sel_o  = 4'd0;
        wbm_we_o   = 1'b0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        if (own_i) begin
            wbm_addr_o = iwbs_addr_i;
            wbm_sel_o  = I_SEL;
            wbm_we_o   = I_WE;
            wbm_cyc_o  = iwbs_cyc_i & ~expire;
            wbm_stb_o  = iwbs_stb_i & ~expire;
        end else if (own_d) begin
            wbm_addr_o = dwbs_addr_i;
            wbm_dat_o  = dwbs_dat_i;
            wbm_sel_o  = dwbs_sel_i;
            wbm_we_o   = dwbs_we_i;
            wbm_cyc_o  = dwbs_cyc_i & ~expire;
            wbm_stb_o  = dwbs_stb_i & ~expire;
        end
    end

    assign iwbs_dat_o = wbm_dat_i;
    assign dwbs_dat_o = wbm_dat_i;
    assign iwbs_ack_o = own_i & wbm_ack_i;
    assign dwbs_ack_o = own_d & wbm_ack_i;
    assign iwbs_err_o = own_i & (wbm_err_i | expire);
    assign dwbs_err_o = own_d & (wbm_err_i | expire);

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Self-checking bench for titan_wb_arbiter: directed scenarios with literal
// expectations plus a randomized phase checked against an owner-level model.
module tb_titan_wb_arbiter;
    localparam int TO = 8;
`ifdef TITAN_WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] iwbs_addr_i = '0, dwbs_addr_i = '0, dwbs_dat_i = '0, wbm_dat_i = '0;
    logic        iwbs_cyc_i = 0, iwbs_stb_i = 0, dwbs_we_i = 0, dwbs_cyc_i = 0, dwbs_stb_i = 0;
    logic [3:0]  dwbs_sel_i = '0;
    logic        wbm_ack_i = 0, wbm_err_i = 0;
    logic [31:0] iwbs_dat_o, dwbs_dat_o, wbm_addr_o, wbm_dat_o;
    logic        iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;

    always #5 clk = ~clk;

    titan_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .iwbs_addr_i(iwbs_addr_i), .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i),
        .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o),
        .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i), .dwbs_sel_i(dwbs_sel_i),
        .dwbs_we_i(dwbs_we_i), .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i),
        .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o),
        .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model: who owns the bus (0 none, 1 I, 2 D), who was granted last,
    // and how many granted cycles have passed without a bus response.
    int m_own = 0, m_last = 1, m_cnt = 0;
    bit m_ok = 0;

    function automatic bit m_expire();
        return TO_EN && m_own != 0 && m_cnt == TO && !(wbm_ack_i || wbm_err_i);
    endfunction

    always @(posedge clk) begin
        int nxt;
        bit ir, dr, oc;
        nxt = m_own;
        if (rst_i) begin
            m_own <= 0; m_last <= 1; m_cnt <= 0; m_ok <= 1;
        end else if (m_own == 0) begin
            ir = iwbs_cyc_i && iwbs_stb_i;
            dr = dwbs_cyc_i && dwbs_stb_i;
            if (ir && dr)  nxt = (m_last == 1) ? 2 : 1;
            else if (ir)   nxt = 1;
            else if (dr)   nxt = 2;
            m_own <= nxt;
            if (nxt != 0) m_last <= nxt;
            m_cnt <= 0;
        end else begin
            oc = (m_own == 1) ? iwbs_cyc_i : dwbs_cyc_i;
            if (wbm_ack_i || wbm_err_i || !oc || m_expire()) m_own <= 0;
            else m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] ea, ed;
        logic [3:0]  es;
        logic        ew, ec, est, ex;
        if (m_ok) begin
            ex = m_expire();
            ea = '0; ed = '0; es = '0; ew = 0; ec = 0; est = 0;
            if (m_own == 1) begin
                ea = iwbs_addr_i; es = 4'hF; ec = iwbs_cyc_i && !ex; est = iwbs_stb_i && !ex;
            end else if (m_own == 2) begin
                ea = dwbs_addr_i; ed = dwbs_dat_i; es = dwbs_sel_i; ew = dwbs_we_i;
                ec = dwbs_cyc_i && !ex; est = dwbs_stb_i && !ex;
            end
            chk("m_addr", wbm_addr_o, ea);
            chk("m_dat",  wbm_dat_o, ed);
            chk("m_sel",  32'(wbm_sel_o), 32'(es));
            chk("m_we",   32'(wbm_we_o), 32'(ew));
            chk("m_cyc",  32'(wbm_cyc_o), 32'(ec));
            chk("m_stb",  32'(wbm_stb_o), 32'(est));
            chk("m_iack", 32'(iwbs_ack_o), 32'(m_own == 1 && wbm_ack_i));
            chk("m_dack", 32'(dwbs_ack_o), 32'(m_own == 2 && wbm_ack_i));
            chk("m_ierr", 32'(iwbs_err_o), 32'(m_own == 1 && (wbm_err_i || ex)));
            chk("m_derr", 32'(dwbs_err_o), 32'(m_own == 2 && (wbm_err_i || ex)));
            chk("m_idat", iwbs_dat_o, wbm_dat_i);
            chk("m_ddat", dwbs_dat_o, wbm_dat_i);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic quiet();
        iwbs_cyc_i = 0; iwbs_stb_i = 0; dwbs_cyc_i = 0; dwbs_stb_i = 0;
        dwbs_we_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1; quiet();
        tick(); tick();
        rst_i = 0;
    endtask

    initial begin
        int k;
        // reset state
        tick();
        neg();
        chk("rst_cyc", 32'(wbm_cyc_o), 0);
        chk("rst_addr", wbm_addr_o, 0);
        chk("rst_sel", 32'(wbm_sel_o), 0);
        do_reset();

        // I-only read, ack on the third granted cycle
        iwbs_cyc_i = 1; iwbs_stb_i = 1; iwbs_addr_i = 32'h100;
        neg(); chk("iread_idle_cyc", 32'(wbm_cyc_o), 0);
        tick(); neg();
        chk("iread_addr", wbm_addr_o, 32'h100);
        chk("iread_sel", 32'(wbm_sel_o), 32'hF);
        chk("iread_we", 32'(wbm_we_o), 0);
        tick(); tick();
        wbm_ack_i = 1; wbm_dat_i = 32'hDEADBEEF;
        neg();
        chk("iread_ack", 32'(iwbs_ack_o), 1);
        chk("iread_dat", iwbs_dat_o, 32'hDEADBEEF);
        chk("iread_dack", 32'(dwbs_ack_o), 0);
        tick(); quiet();
        neg(); chk("iread_ack_once", 32'(iwbs_ack_o), 0);

        // ties alternate D, I, D, I after reset
        do_reset();
        iwbs_cyc_i = 1; iwbs_stb_i = 1; iwbs_addr_i = 32'hA0;
        dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_addr_i = 32'hB0; dwbs_we_i = 1; dwbs_sel_i = 4'h5;
        for (int g = 0; g < 4; g++) begin
            tick();
            wbm_ack_i = 1;
            neg();
            chk("tie_addr", wbm_addr_o, (g % 2 == 0) ? 32'hB0 : 32'hA0);
            chk("tie_we", 32'(wbm_we_o), (g % 2 == 0) ? 1 : 0);
            chk("tie_dack", 32'(dwbs_ack_o), (g % 2 == 0) ? 1 : 0);
            tick();
            wbm_ack_i = 0;
        end
        quiet();

        // D store
        do_reset();
        dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_we_i = 1;
        dwbs_addr_i = 32'h2000; dwbs_dat_i = 32'h12345678; dwbs_sel_i = 4'b0011;
        tick(); wbm_ack_i = 1;
        neg();
        chk("dst_addr", wbm_addr_o, 32'h2000);
        chk("dst_dat", wbm_dat_o, 32'h12345678);
        chk("dst_sel", 32'(wbm_sel_o), 32'h3);
        chk("dst_we", 32'(wbm_we_o), 1);
        chk("dst_dack", 32'(dwbs_ack_o), 1);
        chk("dst_iack", 32'(iwbs_ack_o), 0);
        tick(); quiet();

        // instruction abort, then a late ack
        do_reset();
        iwbs_cyc_i = 1; iwbs_stb_i = 1; iwbs_addr_i = 32'h300;
        tick(); neg(); chk("abort_cyc_on", 32'(wbm_cyc_o), 1);
        tick(); iwbs_cyc_i = 0; iwbs_stb_i = 0;
        neg(); chk("abort_cyc_fall", 32'(wbm_cyc_o), 0);
        tick(); wbm_ack_i = 1;
        neg();
        chk("late_iack", 32'(iwbs_ack_o), 0);
        chk("late_dack", 32'(dwbs_ack_o), 0);
        tick(); quiet();

        // reset in the middle of a D transfer
        do_reset();
        dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_we_i = 1; dwbs_addr_i = 32'h40; dwbs_sel_i = 4'hC;
        tick(); neg(); chk("rstmid_cyc_on", 32'(wbm_cyc_o), 1);
        tick(); rst_i = 1;
        tick(); wbm_ack_i = 1; wbm_err_i = 1;
        neg();
        chk("rstmid_cyc", 32'(wbm_cyc_o), 0);
        chk("rstmid_addr", wbm_addr_o, 0);
        chk("rstmid_we", 32'(wbm_we_o), 0);
        chk("rstmid_dack", 32'(dwbs_ack_o), 0);
        chk("rstmid_derr", 32'(dwbs_err_o), 0);
        rst_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
        tick(); tick(); neg();
        chk("rstmid_regrant", wbm_addr_o, 32'h40);
        wbm_ack_i = 1; tick(); quiet();

        if (TO_EN) begin
            do_reset();
            dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_addr_i = 32'h500;
            tick();
            k = 1;
            while (k <= 30) begin
                neg();
                if (dwbs_err_o) break;
                tick();
                k++;
            end
            chk("to_pulse_cycle", k, TO + 1);
            chk("to_cyc_forced", 32'(wbm_cyc_o), 0);
            tick(); neg(); chk("to_idle", 32'(wbm_cyc_o), 0);
            chk("to_err_once", 32'(dwbs_err_o), 0);
            tick(); neg(); chk("to_next_served", 32'(wbm_cyc_o), 1);
            wbm_ack_i = 1; tick(); quiet();
        end

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_i       = ($urandom_range(0, 99) == 0);
            iwbs_cyc_i  = ($urandom_range(0, 9) < 7);
            iwbs_stb_i  = ($urandom_range(0, 9) < 8);
            dwbs_cyc_i  = ($urandom_range(0, 9) < 7);
            dwbs_stb_i  = ($urandom_range(0, 9) < 8);
            dwbs_we_i   = 1'($urandom);
            dwbs_sel_i  = 4'($urandom);
            iwbs_addr_i = $urandom;
            dwbs_addr_i = $urandom;
            dwbs_dat_i  = $urandom;
            wbm_dat_i   = $urandom;
            wbm_ack_i   = ($urandom_range(0, 9) < 3);
            wbm_err_i   = ($urandom_range(0, 9) == 0);
            tick();
        end
        quiet(); rst_i = 0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
